// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, stall/redirect control from later stages,
// and the IF/ID pipeline register outputs.
interface fetch_stage_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       addr;
  logic [15:0]      instruction;
  logic             stall;
  logic             redirect_valid;
  logic [7:0]       redirect_pc;
  logic [15:0]      ifid_instr;
  logic [7:0]       ifid_pc;
  logic             ifid_valid;
  logic             ifid_pred_taken;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output addr, ifid_instr, ifid_pc, ifid_valid, ifid_pred_taken, fetch_count,
    input  instruction, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  addr, ifid_instr, ifid_pc, ifid_valid, ifid_pred_taken, fetch_count,
    output instruction, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, folds unconditional JMP at fetch and
// loads the IF/ID register, honouring redirect (highest) then stall.
module fetch_stage #(
  parameter logic [7:0]  RESET_PC   = 8'h00,
  parameter logic [15:0] NOP_INSTR  = 16'h1000,
  parameter logic [3:0]  JMP_OPCODE = 4'b1001,
  parameter int          CNT_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.master bus
);

  logic [7:0]       pc, next_pc;
  logic [15:0]      ifid_instr;
  logic [7:0]       ifid_pc;
  logic             ifid_valid;
  logic             ifid_pred_taken;
  logic [CNT_W-1:0] fetch_count;
  logic             is_jmp;

  assign is_jmp = (bus.instruction[15:12] == JMP_OPCODE);
  assign bus.addr = pc;

  // Redirect beats stall, so a stalled decode never pins a wrong-path fetch.
  always_comb begin
    next_pc = pc;
    if (bus.redirect_valid)  next_pc = bus.redirect_pc;
    else if (bus.stall)      next_pc = pc;
    else if (is_jmp)         next_pc = bus.instruction[7:0];
    else                     next_pc = pc + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= RESET_PC;
      ifid_instr      <= NOP_INSTR;
      ifid_pc         <= 8'h00;
      ifid_valid      <= 1'b0;
      ifid_pred_taken <= 1'b0;
      fetch_count     <= '0;
    end else begin
      pc <= next_pc;
      if (bus.redirect_valid) begin
        ifid_instr      <= NOP_INSTR;
        ifid_pc         <= pc;
        ifid_valid      <= 1'b0;
        ifid_pred_taken <= 1'b0;
      end else if (!bus.stall) begin
        ifid_instr      <= bus.instruction;
        ifid_pc         <= pc;
        ifid_valid      <= 1'b1;
        ifid_pred_taken <= is_jmp;
        fetch_count     <= fetch_count + 1'b1;
      end
    end
  end

  assign bus.ifid_instr      = ifid_instr;
  assign bus.ifid_pc         = ifid_pc;
  assign bus.ifid_valid      = ifid_valid;
  assign bus.ifid_pred_taken = ifid_pred_taken;
  assign bus.fetch_count     = fetch_count;

endmodule
